regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file for the RISC-V core with an attached scoreboard. Provides two combinational read ports with writeback bypass, one writeback port, and per-register busy bits for pending writes. After reset it clears the array by sequentially sweeping one entry per cycle. Sits between decode/issue (reads, allocation) and the writeback stage.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
ZERO_REG, 1, when 1 index 0 is hardwired to zero and never busy; when 0 index 0 is an ordinary register
AW (localparam), $clog2(NREGS), register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
init_done  out  1  high once the clear sweep has completed
rs1  in  AW  read port 1 index
rs2  in  AW  read port 2 index
rdata1  out  XLEN  read port 1 data
rdata2  out  XLEN  read port 2 data
rs1_busy  out  1  rs1 has a pending write not yet satisfied
rs2_busy  out  1  rs2 has a pending write not yet satisfied
alloc_valid  in  1  issue requests ownership of alloc_rd
alloc_rd  in  AW  destination register being allocated
alloc_ready  out  1  allocation can be accepted this cycle
wb_valid  in  1  writeback valid
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback data
wb_err  out  1  sticky flag: writeback to a non-busy register occurred

Behaviour:
- FSM states: INIT and READY. While rst is high: state<=INIT, sweep counter<=0, all busy bits<=0, wb_err<=0.
- Reset output values: init_done=0, alloc_ready=0, rdata1/rdata2=0, rs1_busy/rs2_busy=0, wb_err=0.
- INIT:
  - Each cycle, write 0 to regs[cnt] and increment cnt.
  - After the cycle that writes index NREGS-1, go to READY. init_done rises exactly NREGS cycles after rst is sampled low.
  - In INIT, rdata*=0, rs*_busy=0, alloc_ready=0, and wb_valid and alloc_valid are ignored.
  - Asserting rst during INIT restarts the sweep from index 0.
- READY:
  - init_done=1. The state remains READY until rst is asserted.
- Read path (combinational, READY only):
  - If ZERO_REG and rsN==0, rdataN=0.
  - Otherwise, if wb_valid and wb_rd==rsN, rdataN=wb_data (bypass).
  - Otherwise, rdataN=regs[rsN].
- Busy outputs:
  - rsN_busy = busy[rsN] & ~(wb_valid & wb_rd==rsN).
  - rsN_busy is always 0 for index 0 when ZERO_REG=1.
- Allocation:
  - alloc_ready = init_done & ~busy[alloc_rd]. It is combinational and may depend on alloc_rd.
  - A handshake occurs when alloc_valid & alloc_ready; it sets busy[alloc_rd] on the next edge.
  - Allocation of index 0 with ZERO_REG=1 is accepted (alloc_ready=1), but no busy bit is set.
- Writeback:
  - wb_valid writes wb_data into regs[wb_rd] on the edge and clears busy[wb_rd].
  - With ZERO_REG=1 and wb_rd==0, the write is dropped and has no effect.
  - wb_valid to a register whose busy bit is 0 still writes the data and sets wb_err. wb_err is cleared only by rst.
- Simultaneous allocation and writeback to the same rd:
  - The data is written and busy ends at 1 (allocation wins).
  - alloc_ready in that cycle uses the pre-edge busy value. A busy register cannot be reallocated in the same cycle it is written back.
- There is only one write port, so no write-write conflict is possible.

Optional Feature:
REGFILE_DBG_EN
- Defined: adds ports dbg_addr (in, AW), dbg_data (out, XLEN) and dbg_busy (out, NREGS).
  - dbg_data is a registered (1-cycle latency) raw read of regs[dbg_addr], with no bypass and no zero forcing.
  - dbg_busy is the live busy vector.
  - Both outputs are 0 in reset.
  - Two testbench tasks are also provided: read_reg(idx, val) and dump_regs, which prints every entry and its busy bit.
- Not defined: these ports and tasks are absent; the core behaviour is identical.

Test Plan:
- Sweep timing:
  - Stimulus: rst high 3 cycles, then low, NREGS=32.
  - Required: init_done rises on the 32nd edge after release; alloc_ready=0 and rdata1=0 throughout; all registers read 0 afterwards.
- Writeback and bypass:
  - Stimulus: after init, wb x5=0xDEADBEEF with rs1=5 in the same cycle.
  - Required: rdata1=0xDEADBEEF in that cycle (bypass) and in the next cycle (array).
- Scoreboard:
  - Stimulus: alloc x7, then rs2=7.
  - Required: rs2_busy=1 and alloc_ready=0 for alloc_rd=7. After wb x7=0x12, rs2_busy=0 and rdata2=0x12.
- Same-cycle allocation and writeback:
  - Stimulus: x9 busy; wb x9=0x55 and alloc x9 in the same cycle.
  - Required: alloc_ready=0, so x9 is written and busy cleared. A follow-up allocation of x9 the next cycle is accepted; x9 stays busy and reads 0x55.
- Zero register and error flag:
  - Stimulus: alloc x0 and wb x0=0xFFFF_FFFF; then wb x3 with x3 not busy.
  - Required: x0 reads 0 and is never busy. wb_err goes to 1 after the x3 write and stays 1 until rst.
- Reset mid-sweep:
  - Stimulus: assert rst at cycle 10 of INIT for 1 cycle, with a prior value 0xAB in x20.
  - Required: init_done rises 32 cycles after the second release; x20 reads 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two read ports, allocation handshake and writeback port.
// With REGFILE_DBG_EN defined it also carries the debug read address/data and busy vector.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic             init_done;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             alloc_valid;
  logic [AW-1:0]    alloc_rd;
  logic             alloc_ready;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             wb_err;

`ifdef REGFILE_DBG_EN
  logic [AW-1:0]    dbg_addr;
  logic [XLEN-1:0]  dbg_data;
  logic [NREGS-1:0] dbg_busy;

  modport master (
    output rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data, dbg_addr,
    input  init_done, rdata1, rdata2, rs1_busy, rs2_busy, alloc_ready, wb_err,
           dbg_data, dbg_busy
  );

  modport slave (
    input  rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data, dbg_addr,
    output init_done, rdata1, rdata2, rs1_busy, rs2_busy, alloc_ready, wb_err,
           dbg_data, dbg_busy
  );
`else
  modport master (
    output rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data,
    input  init_done, rdata1, rdata2, rs1_busy, rs2_busy, alloc_ready, wb_err
  );

  modport slave (
    input  rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data,
    output init_done, rdata1, rdata2, rs1_busy, rs2_busy, alloc_ready, wb_err
  );
`endif
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register scoreboard, writeback bypass and post-reset clear sweep.
// Optional macro REGFILE_DBG_EN adds a registered raw debug read port and the live busy vector.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    cnt;
  logic             sweep_last;
  logic             ready;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_err_q;

  logic             wb_en;
  logic             alloc_ok;
  logic             alloc_set;

  function automatic logic is_zero(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Zero register beats the bypass, the bypass beats the stored entry.
  function automatic logic [XLEN-1:0] read_mux(
    input logic            rdy,
    input logic [AW-1:0]   idx,
    input logic            wv,
    input logic [AW-1:0]   wr,
    input logic [XLEN-1:0] wd,
    input logic [XLEN-1:0] entry
  );
    if (!rdy || is_zero(idx)) return '0;
    if (wv && (wr == idx))    return wd;
    return entry;
  endfunction

  function automatic logic busy_mux(
    input logic          rdy,
    input logic [AW-1:0] idx,
    input logic          wv,
    input logic [AW-1:0] wr,
    input logic          bit_in
  );
    return rdy && !is_zero(idx) && bit_in && !(wv && (wr == idx));
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  assign sweep_last = (cnt == AW'(NREGS - 1));

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = 1'b0;
    case (state)
      READY:   ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == INIT) cnt <= cnt + AW'(1);
  end

  assign wb_en     = ready && bus.wb_valid && !is_zero(bus.wb_rd);
  assign alloc_ok  = ready && !busy[bus.alloc_rd];
  assign alloc_set = bus.alloc_valid && alloc_ok && !is_zero(bus.alloc_rd);

  // Sweep and writeback never overlap: writeback is only honoured in READY.
  always_ff @(posedge clk) begin
    if (state == INIT) regs[cnt] <= '0;
    else if (wb_en)    regs[bus.wb_rd] <= bus.wb_data;
  end

  // Allocation is applied after the writeback clear so a same-edge allocation wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)     busy_nxt[bus.wb_rd]    = 1'b0;
    if (alloc_set) busy_nxt[bus.alloc_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                         wb_err_q <= 1'b0;
    else if (wb_en && !busy[bus.wb_rd]) wb_err_q <= 1'b1;
  end

  always_comb begin
    bus.init_done   = ready;
    bus.alloc_ready = alloc_ok;
    bus.wb_err      = wb_err_q;
    bus.rdata1      = read_mux(ready, bus.rs1, bus.wb_valid, bus.wb_rd, bus.wb_data, regs[bus.rs1]);
    bus.rdata2      = read_mux(ready, bus.rs2, bus.wb_valid, bus.wb_rd, bus.wb_data, regs[bus.rs2]);
    bus.rs1_busy    = busy_mux(ready, bus.rs1, bus.wb_valid, bus.wb_rd, busy[bus.rs1]);
    bus.rs2_busy    = busy_mux(ready, bus.rs2, bus.wb_valid, bus.wb_rd, busy[bus.rs2]);
  end

`ifdef REGFILE_DBG_EN
  logic [XLEN-1:0] dbg_data_p1;

  // Debug read stage: one register of latency, raw array contents
  always_ff @(posedge clk) begin
    if (rst) dbg_data_p1 <= '0;
    else     dbg_data_p1 <= regs[bus.dbg_addr];
  end

  assign bus.dbg_data = dbg_data_p1;
  assign bus.dbg_busy = rst ? '0 : busy;
`endif

  zero_never_busy: assert property (@(posedge clk) disable iff (rst)
    !((ZERO_REG != 0) && busy[0]));

  no_busy_during_init: assert property (@(posedge clk) disable iff (rst)
    (state == INIT) |-> (busy == '0));

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against a behavioural register/scoreboard model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_bsy   = '0;
  logic             m_err   = 1'b0;
  logic             m_ready = 1'b0;
  int               m_cnt   = 0;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.rs1 = '0; bus.rs2 = '0;
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
`ifdef REGFILE_DBG_EN
    bus.dbg_addr = '0;
`endif
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic cycle();
    logic fire;
    @(posedge clk);
    if (rst) begin
      m_bsy = '0; m_err = 1'b0; m_cnt = 0; m_ready = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == NREGS - 1) m_ready = 1'b1;
      m_cnt++;
    end else begin
      fire = bus.alloc_valid && !m_bsy[bus.alloc_rd];
      if (bus.wb_valid && bus.wb_rd != 0) begin
        if (!m_bsy[bus.wb_rd]) m_err = 1'b1;
        m_mem[bus.wb_rd] = bus.wb_data;
        m_bsy[bus.wb_rd] = 1'b0;
      end
      if (fire && bus.alloc_rd != 0) m_bsy[bus.alloc_rd] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] rs);
    if (!m_ready || rs == 0) return '0;
    if (bus.wb_valid && bus.wb_rd == rs) return bus.wb_data;
    return m_mem[rs];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] rs);
    return m_ready && (rs != 0) && m_bsy[rs] && !(bus.wb_valid && bus.wb_rd == rs);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) cycle();
    checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b exp=0", bus.init_done); end
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL rst_alloc_ready got=%b exp=0", bus.alloc_ready); end
    checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL rst_rdata1 got=%h exp=0", bus.rdata1); end
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL rst_rs1_busy got=%b exp=0", bus.rs1_busy); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL rst_wb_err got=%b exp=0", bus.wb_err); end
    rst = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      bus.rs1 = AW'($urandom); bus.alloc_rd = AW'($urandom); bus.alloc_valid = 1'($urandom);
      bus.wb_valid = 1'($urandom); bus.wb_rd = AW'($urandom); bus.wb_data = $urandom;
      cycle();
      checks++; if (bus.init_done !== 1'(k == NREGS)) begin failures++; $display("FAIL sweep_init_done edge=%0d got=%b exp=%b", k, bus.init_done, k == NREGS); end
      if (k < NREGS) begin
        checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL sweep_alloc_ready edge=%0d got=%b exp=0", k, bus.alloc_ready); end
        checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL sweep_rdata1 edge=%0d got=%h exp=0", k, bus.rdata1); end
      end
    end
    idle();
    for (int i = 0; i < NREGS; i++) begin
      bus.rs1 = AW'(i); bus.rs2 = AW'(NREGS - 1 - i);
      #1;
      checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL cleared_rdata1 x%0d got=%h exp=0", i, bus.rdata1); end
      checks++; if (bus.rdata2 !== '0) begin failures++; $display("FAIL cleared_rdata2 x%0d got=%h exp=0", NREGS - 1 - i, bus.rdata2); end
      checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL cleared_busy x%0d got=%b exp=0", i, bus.rs1_busy); end
    end
  endtask

  task automatic test_wb_bypass();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 5; cycle();
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF; bus.rs1 = 5;
    #1;
    checks++; if (bus.rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rdata1 got=%h exp=deadbeef", bus.rdata1); end
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL bypass_busy got=%b exp=0", bus.rs1_busy); end
    cycle();
    idle(); bus.rs1 = 5;
    #1;
    checks++; if (bus.rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL array_rdata1 got=%h exp=deadbeef", bus.rdata1); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL bypass_wb_err got=%b exp=0", bus.wb_err); end
  endtask

  task automatic test_scoreboard();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 7;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL sb_alloc_ready_free got=%b exp=1", bus.alloc_ready); end
    cycle();
    idle(); bus.rs2 = 7; bus.alloc_rd = 7;
    #1;
    checks++; if (bus.rs2_busy !== 1'b1) begin failures++; $display("FAIL sb_rs2_busy got=%b exp=1", bus.rs2_busy); end
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL sb_alloc_ready_busy got=%b exp=0", bus.alloc_ready); end
    bus.wb_valid = 1'b1; bus.wb_rd = 7; bus.wb_data = 32'h12;
    #1;
    checks++; if (bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL sb_wb_rs2_busy got=%b exp=0", bus.rs2_busy); end
    checks++; if (bus.rdata2 !== 32'h12) begin failures++; $display("FAIL sb_wb_rdata2 got=%h exp=12", bus.rdata2); end
    cycle();
    idle(); bus.rs2 = 7;
    #1;
    checks++; if (bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL sb_after_rs2_busy got=%b exp=0", bus.rs2_busy); end
    checks++; if (bus.rdata2 !== 32'h12) begin failures++; $display("FAIL sb_after_rdata2 got=%h exp=12", bus.rdata2); end
  endtask

  task automatic test_same_cycle();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 9; cycle();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 9;
    bus.wb_valid = 1'b1; bus.wb_rd = 9; bus.wb_data = 32'h55;
    #1;
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL same_alloc_ready got=%b exp=0", bus.alloc_ready); end
    cycle();
    idle(); bus.rs1 = 9; bus.alloc_valid = 1'b1; bus.alloc_rd = 9;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL same_cleared_busy got=%b exp=0", bus.rs1_busy); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL same_realloc_ready got=%b exp=1", bus.alloc_ready); end
    cycle();
    idle(); bus.rs1 = 9;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL same_realloc_busy got=%b exp=1", bus.rs1_busy); end
    checks++; if (bus.rdata1 !== 32'h55) begin failures++; $display("FAIL same_rdata1 got=%h exp=55", bus.rdata1); end
  endtask

  task automatic test_zero_err();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 0;
    bus.wb_valid = 1'b1; bus.wb_rd = 0; bus.wb_data = 32'hFFFF_FFFF; bus.rs1 = 0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL zero_alloc_ready got=%b exp=1", bus.alloc_ready); end
    checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL zero_bypass_rdata1 got=%h exp=0", bus.rdata1); end
    cycle();
    idle(); bus.rs1 = 0; bus.rs2 = 0;
    #1;
    checks++; if (bus.rdata2 !== '0) begin failures++; $display("FAIL zero_rdata2 got=%h exp=0", bus.rdata2); end
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", bus.rs1_busy); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL zero_wb_err got=%b exp=0", bus.wb_err); end
    bus.wb_valid = 1'b1; bus.wb_rd = 3; bus.wb_data = 32'h3333;
    cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.wb_err !== 1'b1) begin failures++; $display("FAIL err_sticky i=%0d got=%b exp=1", i, bus.wb_err); end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.rs1 = AW'($urandom); bus.rs2 = AW'($urandom);
      bus.alloc_valid = 1'($urandom); bus.alloc_rd = AW'($urandom);
      bus.wb_valid = 1'($urandom); bus.wb_rd = AW'($urandom); bus.wb_data = $urandom;
      if ($urandom_range(0, 3) == 0) bus.rs1 = bus.wb_rd;
      #1;
      checks++; if (bus.rdata1 !== exp_rdata(bus.rs1)) begin failures++; $display("FAIL rand_rdata1 n=%0d got=%h exp=%h", n, bus.rdata1, exp_rdata(bus.rs1)); end
      checks++; if (bus.rdata2 !== exp_rdata(bus.rs2)) begin failures++; $display("FAIL rand_rdata2 n=%0d got=%h exp=%h", n, bus.rdata2, exp_rdata(bus.rs2)); end
      checks++; if (bus.rs1_busy !== exp_busy(bus.rs1)) begin failures++; $display("FAIL rand_rs1_busy n=%0d got=%b exp=%b", n, bus.rs1_busy, exp_busy(bus.rs1)); end
      checks++; if (bus.rs2_busy !== exp_busy(bus.rs2)) begin failures++; $display("FAIL rand_rs2_busy n=%0d got=%b exp=%b", n, bus.rs2_busy, exp_busy(bus.rs2)); end
      checks++; if (bus.alloc_ready !== (m_ready && !m_bsy[bus.alloc_rd])) begin failures++; $display("FAIL rand_alloc_ready n=%0d got=%b exp=%b", n, bus.alloc_ready, m_ready && !m_bsy[bus.alloc_rd]); end
      checks++; if (bus.wb_err !== m_err) begin failures++; $display("FAIL rand_wb_err n=%0d got=%b exp=%b", n, bus.wb_err, m_err); end
      cycle();
    end
    idle();
  endtask

  task automatic test_reset_midsweep();
    idle(); bus.alloc_valid = 1'b1; bus.alloc_rd = 20; cycle();
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 20; bus.wb_data = 32'hAB; cycle();
    idle(); bus.rs1 = 20;
    #1;
    checks++; if (bus.rdata1 !== 32'hAB) begin failures++; $display("FAIL mid_pre_rdata1 got=%h exp=ab", bus.rdata1); end
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++; if (bus.init_done !== 1'b0) begin failures++; $display("FAIL mid_first_init_done edge=%0d got=%b exp=0", k, bus.init_done); end
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      cycle();
      checks++; if (bus.init_done !== 1'(k == NREGS)) begin failures++; $display("FAIL mid_init_done edge=%0d got=%b exp=%b", k, bus.init_done, k == NREGS); end
    end
    bus.rs1 = 20;
    #1;
    checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL mid_x20 got=%h exp=0", bus.rdata1); end
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL mid_x20_busy got=%b exp=0", bus.rs1_busy); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL mid_wb_err got=%b exp=0", bus.wb_err); end
  endtask

`ifdef REGFILE_DBG_EN
  task automatic read_reg(input int idx, output logic [XLEN-1:0] val);
    bus.dbg_addr = AW'(idx);
    cycle();
    val = bus.dbg_data;
  endtask

  task automatic dump_regs();
    logic [XLEN-1:0] v;
    for (int i = 0; i < NREGS; i++) begin
      read_reg(i, v);
      $display("x%0d = %h busy=%0b", i, v, bus.dbg_busy[i]);
    end
  endtask

  task automatic test_dbg();
    logic [XLEN-1:0] v;
    idle();
    for (int i = 0; i < 6; i++) begin
      int idx;
      idx = $urandom_range(1, NREGS - 1);
      read_reg(idx, v);
      checks++; if (v !== m_mem[idx]) begin failures++; $display("FAIL dbg_data x%0d got=%h exp=%h", idx, v, m_mem[idx]); end
      checks++; if (bus.dbg_busy !== m_bsy) begin failures++; $display("FAIL dbg_busy got=%h exp=%h", bus.dbg_busy, m_bsy); end
    end
    dump_regs();
  endtask
`endif

  initial begin
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    idle();
`ifdef REGFILE_DBG_EN
    bus.dbg_addr = '0;
`endif
    test_reset();
    test_wb_bypass();
    test_scoreboard();
    test_same_cycle();
    test_zero_err();
    test_random();
`ifdef REGFILE_DBG_EN
    test_dbg();
`endif
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
